// File: rtl/bram1_arbiter.sv
// rtl/bram1_arbiter.sv - two-port round-robin arbiter/sequencer for the byte-wide data BRAM
// Optional feature macro: BRAM_ARB_STATS_EN adds per-port ACK counters P0_CNT/P1_CNT.
module bram1_arbiter #(
    parameter int          ADDR_WIDTH = 13,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  P0_REQ,
    input  logic                  P0_WE,
    input  logic [ADDR_WIDTH-1:0] P0_ADDR,
    input  logic [7:0]            P0_WDATA,
    output logic                  P0_ACK,
    output logic [7:0]            P0_RDATA,
    input  logic                  P1_REQ,
    input  logic                  P1_WE,
    input  logic [ADDR_WIDTH-1:0] P1_ADDR,
    input  logic [7:0]            P1_WDATA,
    output logic                  P1_ACK,
    output logic [7:0]            P1_RDATA,
    output logic [ADDR_WIDTH-1:0] MEM_W_ADDR,
    output logic [ADDR_WIDTH-1:0] MEM_R_ADDR,
    output logic                  MEM_WRITE_EN,
    output logic                  MEM_READ_EN,
    output logic [7:0]            MEM_DIN,
    input  logic [7:0]            MEM_DOUT
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [31:0]           P0_CNT,
    output logic [31:0]           P1_CNT
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    win;
    logic                    last;
    logic                    cmd_we;
    logic                    grant;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_wdata;

    // Winner selection: a lone requester wins; on a tie the port that did not win last time
    // gets the grant, unless fixed priority pins it to port 0.
    always_comb begin
        grant = 1'b0;
        if (P0_REQ && P1_REQ) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last;
        end else begin
            grant = P1_REQ;
        end
        sel_we    = grant ? P1_WE    : P0_WE;
        sel_addr  = grant ? P1_ADDR  : P0_ADDR;
        sel_wdata = grant ? P1_WDATA : P0_WDATA;
    end

    // Next-state logic: one access in flight, IDLE -> ACCESS -> DONE -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (P0_REQ || P1_REQ) next_state = ACCESS;
            ACCESS:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Command register, read-data capture and ACK pulse; unused MEM address/data hold.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            win          <= 1'b0;
            last         <= 1'b1;
            cmd_we       <= 1'b0;
            MEM_W_ADDR   <= '0;
            MEM_R_ADDR   <= '0;
            MEM_DIN      <= '0;
            MEM_WRITE_EN <= 1'b0;
            MEM_READ_EN  <= 1'b0;
            P0_ACK       <= 1'b0;
            P1_ACK       <= 1'b0;
            P0_RDATA     <= '0;
            P1_RDATA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (P0_REQ || P1_REQ) begin
                        win    <= grant;
                        last   <= grant;
                        cmd_we <= sel_we;
                        if (sel_we) begin
                            MEM_W_ADDR   <= sel_addr;
                            MEM_DIN      <= sel_wdata;
                            MEM_WRITE_EN <= 1'b1;
                        end else begin
                            MEM_R_ADDR   <= sel_addr;
                            MEM_READ_EN  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    MEM_WRITE_EN <= 1'b0;
                    MEM_READ_EN  <= 1'b0;
                    if (!cmd_we) begin
                        if (win) P1_RDATA <= MEM_DOUT;
                        else     P0_RDATA <= MEM_DOUT;
                    end
                    P0_ACK <= ~win;
                    P1_ACK <= win;
                end
                DONE: begin
                    P0_ACK <= 1'b0;
                    P1_ACK <= 1'b0;
                end
                default: begin
                    P0_ACK <= 1'b0;
                    P1_ACK <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRAM_ARB_STATS_EN
    // ACK counters: bumped together with the ACK they count, wrapping naturally at 32 bits.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            P0_CNT <= '0;
            P1_CNT <= '0;
        end else if (state == ACCESS) begin
            if (win) P1_CNT <= P1_CNT + 32'd1;
            else     P0_CNT <= P0_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram1_arbiter.sv
// tb/tb_bram1_arbiter.sv - self-checking bench for bram1_arbiter with a transaction-level model
module tb_bram1_arbiter;

    localparam int AW    = 13;
    localparam int FIXED = 0;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          P0_REQ = 1'b0, P0_WE = 1'b0, P1_REQ = 1'b0, P1_WE = 1'b0;
    logic [AW-1:0] P0_ADDR = '0, P1_ADDR = '0;
    logic [7:0]    P0_WDATA = '0, P1_WDATA = '0;
    logic          P0_ACK, P1_ACK;
    logic [7:0]    P0_RDATA, P1_RDATA;
    logic [AW-1:0] MEM_W_ADDR, MEM_R_ADDR;
    logic          MEM_WRITE_EN, MEM_READ_EN;
    logic [7:0]    MEM_DIN;
    logic [7:0]    MEM_DOUT = 8'h00;
`ifdef BRAM_ARB_STATS_EN
    logic [31:0]   P0_CNT, P1_CNT;
`endif

    bram1_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(FIXED)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA),
        .P0_ACK(P0_ACK), .P0_RDATA(P0_RDATA),
        .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA),
        .P1_ACK(P1_ACK), .P1_RDATA(P1_RDATA),
        .MEM_W_ADDR(MEM_W_ADDR), .MEM_R_ADDR(MEM_R_ADDR),
        .MEM_WRITE_EN(MEM_WRITE_EN), .MEM_READ_EN(MEM_READ_EN),
        .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
`ifdef BRAM_ARB_STATS_EN
        , .P0_CNT(P0_CNT), .P1_CNT(P1_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // BRAM behaviour: acts on the negedge while an enable is high.
    logic [7:0] bram [0:(1<<AW)-1];
    always @(negedge CLK) begin
        if (MEM_WRITE_EN) bram[MEM_W_ADDR] <= MEM_DIN;
        if (MEM_READ_EN)  MEM_DOUT <= bram[MEM_R_ADDR];
    end

    // Transaction model: a granted access occupies three cycles; the phase counts cycles since grant.
    logic [7:0]    mmem [0:(1<<AW)-1];
    logic          m_valid = 1'b0;
    int            phase = 0;
    logic          m_last, m_win, m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wd;
    logic          e_ack0, e_ack1, e_we, e_re;
    logic [AW-1:0] e_wa, e_ra;
    logic [7:0]    e_din, e_rd0, e_rd1;
    logic [31:0]   e_cnt0, e_cnt1;
    logic          cnt_preload = 1'b0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_valid = 1'b1; phase = 0; m_last = 1'b1;
            e_ack0 = 0; e_ack1 = 0; e_we = 0; e_re = 0;
            e_wa = '0; e_ra = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
            e_cnt0 = '0; e_cnt1 = '0;
        end else if (m_valid) begin
            if (phase == 0) begin
                if (P0_REQ || P1_REQ) begin
                    if (P0_REQ && P1_REQ) m_win = (FIXED != 0) ? 1'b0 : (m_last == 1'b0);
                    else                  m_win = P1_REQ;
                    m_last = m_win;
                    m_we   = m_win ? P1_WE : P0_WE;
                    m_addr = m_win ? P1_ADDR : P0_ADDR;
                    m_wd   = m_win ? P1_WDATA : P0_WDATA;
                    if (m_we) begin
                        e_wa = m_addr; e_din = m_wd; e_we = 1'b1; mmem[m_addr] = m_wd;
                    end else begin
                        e_ra = m_addr; e_re = 1'b1;
                    end
                    phase = 1;
                end
            end else if (phase == 1) begin
                e_we = 1'b0; e_re = 1'b0;
                if (!m_we) begin
                    if (m_win) e_rd1 = mmem[m_addr];
                    else       e_rd0 = mmem[m_addr];
                end
                if (m_win) begin e_ack1 = 1'b1; e_cnt1 = e_cnt1 + 1; end
                else       begin e_ack0 = 1'b1; e_cnt0 = e_cnt0 + 1; end
                phase = 2;
            end else begin
                e_ack0 = 1'b0; e_ack1 = 1'b0; phase = 0;
            end
        end
        if (cnt_preload) e_cnt0 = 32'hFFFF_FFFF;
        #3;
        if (m_valid) begin
            check("ack0",   32'(P0_ACK), 32'(e_ack0));
            check("ack1",   32'(P1_ACK), 32'(e_ack1));
            check("wr_en",  32'(MEM_WRITE_EN), 32'(e_we));
            check("rd_en",  32'(MEM_READ_EN), 32'(e_re));
            check("w_addr", 32'(MEM_W_ADDR), 32'(e_wa));
            check("r_addr", 32'(MEM_R_ADDR), 32'(e_ra));
            check("din",    32'(MEM_DIN), 32'(e_din));
            check("rdata0", 32'(P0_RDATA), 32'(e_rd0));
            check("rdata1", 32'(P1_RDATA), 32'(e_rd1));
`ifdef BRAM_ARB_STATS_EN
            check("cnt0", P0_CNT, e_cnt0);
            check("cnt1", P1_CNT, e_cnt1);
`endif
        end
    end

    int lat;
    int ack_order[$];

    task automatic set0(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        P0_WE = we; P0_ADDR = a; P0_WDATA = d;
    endtask

    task automatic set1(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        P1_WE = we; P1_ADDR = a; P1_WDATA = d;
    endtask

    // Raise the chosen requests, drop each one at the edge that ends its ACK cycle.
    task automatic run(input logic r0, input logic r1);
        logic s0, s1;
        int   c;
        P0_REQ = r0; P1_REQ = r1; s0 = !r0; s1 = !r1; c = 0; lat = -1;
        while (!(s0 && s1) && c < 30) begin
            @(posedge CLK); #1; c++;
            if (s0) P0_REQ = 1'b0;
            if (s1) P1_REQ = 1'b0;
            if (P0_ACK && !s0) begin s0 = 1'b1; ack_order.push_back(0); if (lat < 0) lat = c; end
            if (P1_ACK && !s1) begin s1 = 1'b1; ack_order.push_back(1); if (lat < 0) lat = c; end
        end
        check("ack_arrived", 32'(s0 && s1), 32'd1);
        @(posedge CLK); #1;
        P0_REQ = 1'b0; P1_REQ = 1'b0;
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin bram[i] = 8'h00; mmem[i] = 8'h00; end

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ctl", {4'(P0_ACK), 4'(P1_ACK), 4'(MEM_WRITE_EN), 4'(MEM_READ_EN), P0_RDATA, P1_RDATA}, 32'd0);
        check("rst_mem", {3'd0, MEM_W_ADDR, 3'd0, MEM_R_ADDR}, 32'd0);
        check("rst_din", 32'(MEM_DIN), 32'd0);
        RST_N = 1'b1;

        // Write then read back through port 0, with latency
        set0(1'b1, 13'h0010, 8'hA5); run(1'b1, 1'b0);
        check("wr_latency", 32'(lat), 32'd2);
        set0(1'b0, 13'h0010, 8'h00); run(1'b1, 1'b0);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_a5", 32'(P0_RDATA), 32'h0000_00A5);
        check("rd1_untouched", 32'(P1_RDATA), 32'd0);

        // Simultaneous requests: grant order alternates
        do_reset(1);
        set0(1'b0, 13'h0010, 8'h00); set1(1'b0, 13'h0010, 8'h00);
        ack_order.delete();
        run(1'b1, 1'b1); run(1'b1, 1'b1);
        check("order_len", 32'(ack_order.size()), 32'd4);
        check("order0", 32'(ack_order[0]), 32'd0);
        check("order1", 32'(ack_order[1]), 32'd1);
        check("order2", 32'(ack_order[2]), 32'd0);
        check("order3", 32'(ack_order[3]), 32'd1);
        check("p1_rd_a5", 32'(P1_RDATA), 32'h0000_00A5);
        // After a port-0-only grant, the next tie goes to port 1
        ack_order.delete();
        run(1'b1, 1'b0); run(1'b1, 1'b1);
        check("rr_after_p0", 32'(ack_order[1]), (FIXED != 0) ? 32'd0 : 32'd1);

        // Tie on the same address: port 0 reads the old byte first
        set0(1'b1, 13'h0004, 8'h11); run(1'b1, 1'b0);
        do_reset(1);
        set1(1'b1, 13'h0004, 8'h3C); set0(1'b0, 13'h0004, 8'h00);
        ack_order.delete();
        run(1'b1, 1'b1);
        check("tie_first_p0", 32'(ack_order[0]), 32'd0);
        check("tie_old", 32'(P0_RDATA), 32'h0000_0011);
        run(1'b1, 1'b0);
        check("tie_new", 32'(P0_RDATA), 32'h0000_003C);

        // Reset during ACCESS of a port-1 write: committed, never ACKed
        do_reset(1);
        set1(1'b1, 13'h0020, 8'h77);
        P1_REQ = 1'b1;
        @(posedge CLK); #1;
        check("mid_wr_en", 32'(MEM_WRITE_EN), 32'd1);
        RST_N = 1'b0; P1_REQ = 1'b0;
        @(posedge CLK); #1;
        check("mid_no_ack", 32'(P1_ACK), 32'd0);
        check("mid_idle", 32'(dut.state), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("mid_no_ack2", 32'(P1_ACK), 32'd0);
        set0(1'b0, 13'h0020, 8'h00); run(1'b1, 1'b0);
        check("mid_committed", 32'(P0_RDATA), 32'h0000_0077);

`ifdef BRAM_ARB_STATS_EN
        do_reset(1);
        for (int i = 0; i < 5; i++) run(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) run(1'b0, 1'b1);
        check("cnt0_5", P0_CNT, 32'd5);
        check("cnt1_2", P1_CNT, 32'd2);
        force dut.P0_CNT = 32'hFFFF_FFFF;
        cnt_preload = 1'b1;
        @(posedge CLK); #1;
        cnt_preload = 1'b0;
        release dut.P0_CNT;
        run(1'b1, 1'b0);
        check("cnt0_wrap", P0_CNT, 32'd0);
`endif

        repeat (2) @(posedge CLK);
        #4;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
